// File: rtl/pit_hash_table_pkg.sv
// Shared types and constants for the NDN pending interest table.
// Prefix/index widths, packet-type codes and the table entry layout.
package pit_hash_table_pkg;
    localparam int PREFIX_W = 64;
    localparam int INDEX_W  = 11;
    localparam int LEN_W    = 6;
    localparam int META_W   = 8;
    localparam int DEPTH    = 1 << INDEX_W;

    localparam logic [1:0] PKT_DATA     = 2'b00;
    localparam logic [1:0] PKT_INTEREST = 2'b01;

    typedef struct packed {
        logic                valid;
        logic [PREFIX_W-1:0] prefix;
        logic [LEN_W-1:0]    length;
    } pit_entry_t;

    // Keep prefix bits [len:0]; everything above is treated as don't-care and zeroed.
    function automatic logic [PREFIX_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PREFIX_W-1:0] m;
        for (int i = 0; i < PREFIX_W; i++) m[i] = (i <= int'(len));
        return m;
    endfunction
endpackage

// File: rtl/pit_prefix_hash.sv
// Combinational prefix mask plus XOR-fold of the masked prefix into a table index.
// The top chunk is shorter than INDEX_W and is zero-extended before folding.
module pit_prefix_hash
    import pit_hash_table_pkg::*;
(
    input  logic [PREFIX_W-1:0] prefix_i,
    input  logic [LEN_W-1:0]    length_i,
    output logic [PREFIX_W-1:0] masked_o,
    output logic [INDEX_W-1:0]  index_o
);
    localparam int CHUNKS = (PREFIX_W + INDEX_W - 1) / INDEX_W;

    logic [CHUNKS*INDEX_W-1:0] padded;

    assign masked_o = prefix_i & len_mask(length_i);
    assign padded   = {{(CHUNKS*INDEX_W-PREFIX_W){1'b0}}, masked_o};

    always_comb begin
        index_o = '0;
        for (int c = 0; c < CHUNKS; c++) index_o ^= padded[c*INDEX_W +: INDEX_W];
    end
endmodule

// File: rtl/pit_hash_table.sv
// Pending interest table: records SPI/FIB interests, consumes entries on matching data,
// and reports index/result of the last processed request on registered outputs.
module pit_hash_table
    import pit_hash_table_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PREFIX_W-1:0] SPI_to_PIT_prefix,
    input  logic [LEN_W-1:0]    length,
    input  logic                out_bit,
    input  logic [PREFIX_W-1:0] FIB_to_PIT_prefix,
    input  logic [META_W-1:0]   FIB_to_PIT_metadata,
    input  logic                prefix_ready,
    output logic [INDEX_W-1:0]  table_entry,
    output logic [META_W-1:0]   meta_data,
    output logic                pit_in_bit,
    output logic                rejected,
    output logic                interest_packet
);
    logic [DEPTH-1:0]    valid_q;
    logic [PREFIX_W-1:0] pfx_mem [DEPTH];
    logic [LEN_W-1:0]    len_mem [DEPTH];

    logic                       spi_seen_q, fib_seen_q;
    logic [PREFIX_W+LEN_W-1:0]  spi_last_q;
    logic [PREFIX_W+META_W-1:0] fib_last_q;

    logic [INDEX_W-1:0] table_entry_q;
    logic [META_W-1:0]  meta_data_q;
    logic               pit_in_q, rejected_q, interest_q;

    logic                spi_go, fib_go, fire;
    logic [PREFIX_W-1:0] sel_prefix, masked;
    logic [LEN_W-1:0]    sel_len;
    logic [1:0]          sel_type;
    logic [META_W-1:0]   sel_meta;
    logic [INDEX_W-1:0]  idx;
    pit_entry_t          cur;
    logic                hit, is_int, is_data, accept, do_write, do_clear;

    // A held source fires once; a changed request while held fires again.
    // FIB waits while out_bit is high so it is never lost behind an SPI request.
    assign spi_go = out_bit && (!spi_seen_q || {SPI_to_PIT_prefix, length} != spi_last_q);
    assign fib_go = !out_bit && prefix_ready &&
                    (!fib_seen_q || {FIB_to_PIT_prefix, FIB_to_PIT_metadata} != fib_last_q);
    assign fire   = spi_go || fib_go;

    assign sel_prefix = out_bit ? SPI_to_PIT_prefix : FIB_to_PIT_prefix;
    assign sel_len    = out_bit ? length : FIB_to_PIT_metadata[LEN_W-1:0];
    assign sel_type   = out_bit ? PKT_INTEREST : FIB_to_PIT_metadata[7:6];
    assign sel_meta   = out_bit ? {PKT_INTEREST, length} : FIB_to_PIT_metadata;

    pit_prefix_hash u_hash (
        .prefix_i (sel_prefix),
        .length_i (sel_len),
        .masked_o (masked),
        .index_o  (idx)
    );

    assign cur      = {valid_q[idx], pfx_mem[idx], len_mem[idx]};
    assign hit      = cur.valid && cur.prefix == masked && cur.length == sel_len;
    assign is_int   = sel_type == PKT_INTEREST;
    assign is_data  = sel_type == PKT_DATA;
    assign accept   = is_int ? !cur.valid : (is_data && hit);
    assign do_write = fire && is_int && !cur.valid;
    assign do_clear = fire && is_data && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            spi_seen_q    <= 1'b0;
            fib_seen_q    <= 1'b0;
            spi_last_q    <= '0;
            fib_last_q    <= '0;
            table_entry_q <= '0;
            meta_data_q   <= '0;
            pit_in_q      <= 1'b0;
            rejected_q    <= 1'b0;
            interest_q    <= 1'b0;
        end else begin
            spi_seen_q <= out_bit && (spi_seen_q || spi_go);
            fib_seen_q <= prefix_ready && (fib_seen_q || fib_go);
            if (spi_go) spi_last_q <= {SPI_to_PIT_prefix, length};
            if (fib_go) fib_last_q <= {FIB_to_PIT_prefix, FIB_to_PIT_metadata};
            if (do_write) valid_q[idx] <= 1'b1;
            if (do_clear) valid_q[idx] <= 1'b0;
            if (fire) begin
                table_entry_q <= idx;
                meta_data_q   <= sel_meta;
                pit_in_q      <= accept;
                rejected_q    <= !accept;
                interest_q    <= is_int;
            end
        end
    end

    // Payload storage needs no reset: it is only ever read under its valid bit.
    always_ff @(posedge clk) begin
        if (do_write) begin
            pfx_mem[idx] <= masked;
            len_mem[idx] <= sel_len;
        end
    end

    assign table_entry     = table_entry_q;
    assign meta_data       = meta_data_q;
    assign pit_in_bit      = pit_in_q;
    assign rejected        = rejected_q;
    assign interest_packet = interest_q;
endmodule

// File: tb/tb_pit_hash_table.sv
// Scoreboard bench for pit_hash_table: a reference model pushes the expected output
// state per edge, which is popped and compared one time unit after that edge.
module tb_pit_hash_table;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] spi_pfx = '0, fib_pfx = '0;
    logic [5:0]  len = '0;
    logic [7:0]  fib_md = '0;
    logic        out_bit = 1'b0, prefix_ready = 1'b0;
    logic [10:0] table_entry;
    logic [7:0]  meta_data;
    logic        pit_in_bit, rejected, interest_packet;

    always #5 clk = ~clk;

    pit_hash_table dut (
        .clk(clk), .rst(rst),
        .SPI_to_PIT_prefix(spi_pfx), .length(len), .out_bit(out_bit),
        .FIB_to_PIT_prefix(fib_pfx), .FIB_to_PIT_metadata(fib_md), .prefix_ready(prefix_ready),
        .table_entry(table_entry), .meta_data(meta_data), .pit_in_bit(pit_in_bit),
        .rejected(rejected), .interest_packet(interest_packet)
    );

    localparam logic [63:0] P1 = 64'h24FDBF80A6EF7DA7;
    localparam logic [63:0] P2 = 64'h06E0EAB707C207BD;
    localparam logic [63:0] P3 = 64'h3FCA9F2FF58CD668;

    typedef struct {
        logic [10:0] te;
        logic [7:0]  md;
        logic        pin, rej, ip;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0, failures = 0;

    bit          mvalid [2048];
    logic [63:0] mpfx   [2048];
    logic [5:0]  mlen   [2048];
    bit          m_sseen, m_fseen;
    logic [69:0] m_slast;
    logic [71:0] m_flast;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tmask(input logic [63:0] p, input logic [5:0] l);
        logic [63:0] r = '0;
        for (int i = 0; i <= int'(l); i++) r[i] = p[i];
        return r;
    endfunction

    function automatic logic [10:0] th(input logic [63:0] p, input logic [5:0] l);
        logic [10:0] h = '0;
        logic [63:0] m = tmask(p, l);
        for (int i = 0; i < 64; i++) h[i % 11] ^= m[i];
        return h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2048; i++) mvalid[i] = 0;
        m_sseen = 0; m_fseen = 0; m_slast = '0; m_flast = '0;
        me = '{te: '0, md: '0, pin: 0, rej: 0, ip: 0};
    endtask

    task automatic model_edge();
        bit sgo, fgo, hit, acc;
        logic [63:0] p, mp;
        logic [5:0]  l;
        logic [1:0]  ty;
        logic [7:0]  md;
        logic [10:0] h;
        sgo = out_bit && (!m_sseen || {spi_pfx, len} != m_slast);
        fgo = !out_bit && prefix_ready && (!m_fseen || {fib_pfx, fib_md} != m_flast);
        if (sgo || fgo) begin
            if (sgo) begin p = spi_pfx; l = len; ty = 2'b01; md = {2'b01, len}; end
            else     begin p = fib_pfx; l = fib_md[5:0]; ty = fib_md[7:6]; md = fib_md; end
            mp  = tmask(p, l);
            h   = th(p, l);
            hit = mvalid[h] && mpfx[h] == mp && mlen[h] == l;
            acc = 0;
            if (ty == 2'b01) begin
                acc = !mvalid[h];
                if (acc) begin mvalid[h] = 1; mpfx[h] = mp; mlen[h] = l; end
            end else if (ty == 2'b00 && hit) begin
                acc = 1; mvalid[h] = 0;
            end
            me = '{te: h, md: md, pin: acc, rej: !acc, ip: (ty == 2'b01)};
        end
        if (sgo) m_slast = {spi_pfx, len};
        if (fgo) m_flast = {fib_pfx, fib_md};
        m_sseen = out_bit && (m_sseen || sgo);
        m_fseen = prefix_ready && (m_fseen || fgo);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".te"},  64'(table_entry),     64'(e.te));
        chk({tag, ".md"},  64'(meta_data),       64'(e.md));
        chk({tag, ".pin"}, 64'(pit_in_bit),      64'(e.pin));
        chk({tag, ".rej"}, 64'(rejected),        64'(e.rej));
        chk({tag, ".ip"},  64'(interest_packet), 64'(e.ip));
    endtask

    task automatic step(input string tag, input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_edge();
            q.push_back(me);
            @(posedge clk);
            #1;
            compare(tag);
        end
    endtask

    task automatic spi(input logic [63:0] p, input logic [5:0] l);
        spi_pfx = p; len = l; out_bit = 1'b1;
    endtask

    task automatic fib(input logic [63:0] p, input logic [7:0] m);
        fib_pfx = p; fib_md = m; prefix_ready = 1'b1;
    endtask

    initial begin
        model_reset();
        #23;
        q.push_back(me);
        compare("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        spi(P1, 6'd63);              step("spi_p1_hold", 10);
        spi(P2, 6'd63);              step("spi_p2");
        spi(P1, 6'd63);              step("spi_p1_dup");
        out_bit = 1'b0; fib(P1, 8'h3F); step("fib_data_p1", 2);
        fib(P3, 8'h3F);              step("fib_data_miss");
        fib(P1, 8'h7F);              step("fib_int_p1");
        prefix_ready = 1'b0;
        spi(P2 ^ 64'h801, 6'd63);    step("collision");
        fib(P3, 8'hBF);              step("reserved_blocked");
        out_bit = 1'b0;              step("fib_after_spi", 2);
        fib(P3, 8'h7F);              step("fib_int_p3");
        fib(P3, 8'h3F);              step("fib_data_p3");
        prefix_ready = 1'b0;
        spi(P3, 6'd5);               step("short_len");
        spi(P3 ^ 64'hFF00, 6'd5);    step("short_len_dup");

        // Reset mid-hold: outputs clear at once, held request fires again afterward.
        spi(P1, 6'd20);              step("pre_reset", 2);
        #2 rst = 1'b1; #1;
        model_reset();
        q.push_back(me);
        compare("mid_reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        step("post_reset_hold", 3);

        for (int r = 0; r < 40; r++) begin
            logic [63:0] pool [4];
            pool[0] = P1; pool[1] = P2; pool[2] = P3; pool[3] = P1 ^ P2;
            out_bit      = ($urandom_range(0, 2) == 0);
            prefix_ready = ($urandom_range(0, 3) != 0);
            spi_pfx      = pool[$urandom_range(0, 3)];
            len          = ($urandom_range(0, 1) != 0) ? 6'd63 : 6'($urandom_range(0, 63));
            fib_pfx      = pool[$urandom_range(0, 3)];
            fib_md       = {2'($urandom_range(0, 3)),
                            ($urandom_range(0, 1) != 0) ? 6'd63 : 6'($urandom_range(0, 63))};
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
